wdg_rst_gen: RTL

WDG_RST_GEN -- requirements
Module: wdg_rst_gen

---
 rtl/wdg_rst_gen.sv | 80 ++++++++
 1 files changed

// File: rtl/wdg_rst_gen.sv
// rtl/wdg_rst_gen.sv - system reset pulse generator driven by power-on, watchdog and external requests
module wdg_rst_gen #(
   parameter int HOLD_WIDTH = 8,
   parameter int POR_HOLD   = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  wdg_rst_i,
   input  logic                  ext_rst_i,
   input  logic [HOLD_WIDTH-1:0] hold_i,
   input  logic                  clr_cause_i,
   output logic                  sys_rst_n_o,
   output logic                  busy_o,
   output logic [1:0]            cause_o,
   output logic [7:0]            wdg_rst_cnt_o
);

   typedef enum logic [1:0] {IDLE, ASSERT, WAIT} state_t;

   localparam logic [HOLD_WIDTH-1:0] POR_VAL = HOLD_WIDTH'(POR_HOLD);
   localparam logic [HOLD_WIDTH-1:0] ONE     = HOLD_WIDTH'(1);

   state_t                state, state_nxt;
   logic [HOLD_WIDTH-1:0] cnt, cnt_nxt;
   logic                  ext_s1, ext_s;
   logic                  trig;
   logic [1:0]            set_bits;
   logic [1:0]            cause_nxt;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      trig      = 1'b0;
      case (state)
         IDLE: begin
            if (wdg_rst_i || ext_s) begin
               trig      = 1'b1;
               state_nxt = ASSERT;
               cnt_nxt   = (hold_i == '0) ? ONE : hold_i;
            end
         end
         ASSERT: begin
            cnt_nxt = cnt - ONE;
            if (cnt <= ONE) state_nxt = WAIT;
         end
         WAIT: begin
            // a request level still high must fall before another reset can start
            if (!wdg_rst_i && !ext_s) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign set_bits  = trig ? {ext_s, wdg_rst_i} : 2'b00;
   assign cause_nxt = clr_cause_i ? set_bits : (cause_o | set_bits);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state         <= ASSERT;
         cnt           <= POR_VAL;
         sys_rst_n_o   <= 1'b0;
         cause_o       <= 2'b00;
         wdg_rst_cnt_o <= 8'h00;
         ext_s1        <= 1'b0;
         ext_s         <= 1'b0;
      end else begin
         ext_s1      <= ext_rst_i;
         ext_s       <= ext_s1;
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         sys_rst_n_o <= (state_nxt != ASSERT);
         cause_o     <= cause_nxt;
         if (trig && wdg_rst_i && (wdg_rst_cnt_o != 8'hFF))
            wdg_rst_cnt_o <= wdg_rst_cnt_o + 8'h01;
      end
   end

   assign busy_o = (state != IDLE);

endmodule
